frame_buffer: RTL
=================

Name: frame_buffer

Overview:
- Memory-side responder for the 256x256 raster read/write stream controller.
- Holds one frame of pixels.
- Serves read requests with fixed 1-cycle latency and accepts write-back pixels.
- Counts accepted accesses per frame and flags frame completion and protocol misuse to the surrounding pipeline.

Parameters:
DATA_W, 8, pixel width in bits
ROW_W, 8, row address width (2^ROW_W rows)
COL_W, 8, column address width (2^COL_W columns)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
act  input  1  access window active; rd/wr honoured only while high
rd  input  1  read request
addr_row_r  input  ROW_W  read row address
addr_col_r  input  COL_W  read column address
wr  input  1  write request
addr_row_w  input  ROW_W  write row address
addr_col_w  input  COL_W  write column address
wdata  input  DATA_W  write pixel
ld_en  input  1  preload write strobe (idle-time frame load)
ld_addr  input  ROW_W+COL_W  preload address {row,col}
ld_data  input  DATA_W  preload pixel
rdata  output  DATA_W  read pixel
rvalid  output  1  rdata valid this cycle
rd_cnt  output  ROW_W+COL_W+1  accepted reads this frame
wr_cnt  output  ROW_W+COL_W+1  accepted writes this frame
frame_done  output  1  one-cycle pulse, full frame written
err  output  1  sticky protocol error

Behaviour:
- Reset (rst=0, async) drives the following:
  - rdata=0, rvalid=0, rd_cnt=0, wr_cnt=0, frame_done=0, err=0.
  - Internal act_d=0.
  - Memory array is not reset; its contents survive reset.
- Linear address is {row,col} (row in MSBs). Array depth is FRAME = 2^(ROW_W+COL_W) = 65536 by default.
- Read path:
  - A read is accepted when act=1 and rd=1 at a clock edge.
  - Next cycle: rdata=mem[{addr_row_r,addr_col_r}] and rvalid=1.
  - No accepted read: rvalid=0 next cycle and rdata holds its last value.
  - Back-to-back reads stream one pixel per cycle.
- Write path: a write is accepted when act=1 and wr=1 at a clock edge; mem[{addr_row_w,addr_col_w}] <= wdata.
- Read/write to the same address in the same cycle is read-before-write: rdata returns the old value. The new value is visible to reads from the next edge on.
- Preload:
  - When act=0 and ld_en=1, mem[ld_addr] <= ld_data.
  - When act=1, ld_en is ignored and err is set.
- Protocol errors: any of the following sets err=1. err clears only on reset.
  - rd=1 or wr=1 while act=0. The access is ignored: no rvalid, no array write.
  - ld_en=1 while act=1.
- Frame counters:
  - act_d registers act every cycle. A frame starts on the edge where act=1 and act_d=0.
  - On the frame-start edge, rd_cnt and wr_cnt are cleared to 0, then incremented by that edge's accepted accesses, so they read 1 if an access occurs that edge.
  - On other edges, each counter increments by 1 per accepted access.
  - Counters saturate at FRAME; extra accesses do not wrap and set err.
  - Counters hold their value after act falls, until the next frame start.
- frame_done:
  - Registered. It is 1 for exactly one cycle on the edge after an accepted write brings wr_cnt to FRAME.
  - It is not reasserted while saturated.
- Address wrap: addresses are used as given. The block performs no address arithmetic and no range check (all codes are valid).
- rd and wr are independent and may both be accepted in the same cycle; this is the normal steady state, with write lagging read by 8.

Test Plan:
- Reset mid-stream:
  - Stimulus: after 100 reads with act=1, pulse rst=0 asynchronously.
  - Required: rvalid=0, rd_cnt=0 and err=0 immediately.
  - Required: after release, mem[0x0005] still returns the value preloaded before reset.
- Preload then read:
  - Stimulus: act=0, ld_en writes 0xA5 to 0x0102; then act=1, rd=1, row=0x01, col=0x02 for one cycle.
  - Required: next cycle rvalid=1, rdata=0xA5, rd_cnt=1; the following cycle rvalid=0 with rdata holding 0xA5.
- Collision:
  - Stimulus: mem[0x0300]=0x11; same cycle rd and wr to row 3, col 0 with wdata=0x22.
  - Required: rdata=0x11; a read on the next cycle returns 0x22.
- Full frame:
  - Stimulus: act=1 with 65536 raster reads, and writes lagging by 8 cycles that write pixel = read pixel XOR 0xFF.
  - Required: wr_cnt=65536 and one frame_done pulse, the cycle after the write to 0xFFFF.
  - Required: every location equals its inverted preload; err=0.
- Protocol errors:
  - Stimulus 1: wr=1 with act=0 to 0x0010.
  - Required: mem[0x0010] unchanged, err=1 and stays set.
  - Stimulus 2: ld_en=1 with act=1.
  - Required: array unchanged, err=1.
- Frame restart: with act low after a full frame (wr_cnt=65536), raise act with rd=1 → rd_cnt=1 and wr_cnt=0 next cycle; frame_done=0.

Source files
------------

// File: rtl/frame_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : frame_buffer
// Brief    : One-frame pixel store with 1-cycle read port, write-back port,
//            idle-time preload, per-frame access counters and error flag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module frame_buffer #(
  parameter int DATA_W = 8,
  parameter int ROW_W  = 8,
  parameter int COL_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   act,
  input  logic                   rd,
  input  logic [ROW_W-1:0]       addr_row_r,
  input  logic [COL_W-1:0]       addr_col_r,
  input  logic                   wr,
  input  logic [ROW_W-1:0]       addr_row_w,
  input  logic [COL_W-1:0]       addr_col_w,
  input  logic [DATA_W-1:0]      wdata,
  input  logic                   ld_en,
  input  logic [ROW_W+COL_W-1:0] ld_addr,
  input  logic [DATA_W-1:0]      ld_data,
  output logic [DATA_W-1:0]      rdata,
  output logic                   rvalid,
  output logic [ROW_W+COL_W:0]   rd_cnt,
  output logic [ROW_W+COL_W:0]   wr_cnt,
  output logic                   frame_done,
  output logic                   err
);

  localparam int              c_AW    = ROW_W + COL_W;
  localparam int              c_CW    = c_AW + 1;
  localparam logic [c_CW-1:0] c_FRAME = {1'b1, {c_AW{1'b0}}};
  localparam logic [c_CW-1:0] c_ONE   = {{c_AW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] r_mem [0:(1<<c_AW)-1];
  logic              r_act_d;

  logic            w_rd_acc;
  logic            w_wr_acc;
  logic            w_ld_acc;
  logic            w_start;
  logic [c_AW-1:0] w_raddr;
  logic [c_AW-1:0] w_waddr;
  logic [c_CW-1:0] w_rd_base;
  logic [c_CW-1:0] w_wr_base;
  logic            w_rd_sat;
  logic            w_wr_sat;
  logic            w_proto_err;

  assign w_rd_acc  = act & rd;
  assign w_wr_acc  = act & wr;
  assign w_ld_acc  = ~act & ld_en;
  assign w_start   = act & ~r_act_d;
  assign w_raddr   = {addr_row_r, addr_col_r};
  assign w_waddr   = {addr_row_w, addr_col_w};

  // Counters restart from zero on the frame-start edge, then count that edge's accesses.
  assign w_rd_base = w_start ? '0 : rd_cnt;
  assign w_wr_base = w_start ? '0 : wr_cnt;
  assign w_rd_sat  = w_rd_acc & (w_rd_base == c_FRAME);
  assign w_wr_sat  = w_wr_acc & (w_wr_base == c_FRAME);

  assign w_proto_err = (~act & (rd | wr)) | (act & ld_en) | w_rd_sat | w_wr_sat;

  // Array has no reset so a loaded frame survives a pipeline reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_waddr] <= wdata;
    end else if (w_ld_acc) begin
      r_mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata      <= '0;
      rvalid     <= 1'b0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      r_act_d    <= 1'b0;
    end else begin
      r_act_d <= act;
      rvalid  <= w_rd_acc;
      if (w_rd_acc) begin
        rdata <= r_mem[w_raddr];
      end
      rd_cnt     <= (w_rd_acc && !w_rd_sat) ? w_rd_base + c_ONE : w_rd_base;
      wr_cnt     <= (w_wr_acc && !w_wr_sat) ? w_wr_base + c_ONE : w_wr_base;
      frame_done <= w_wr_acc && !w_wr_sat && ((w_wr_base + c_ONE) == c_FRAME);
      if (w_proto_err) begin
        err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
